// File: rtl/keypad_pkg.sv
// keypad_pkg: scanner states, column drive patterns and row-decode helpers.
// Shared by keypad_sync and keypad_scan.
package keypad_pkg;

    typedef enum logic [1:0] {
        S_SCAN,
        S_DEBOUNCE,
        S_PRESSED,
        S_RELEASE
    } state_t;

    localparam logic [3:0] COL_0     = 4'b1110;
    localparam logic [3:0] COL_1     = 4'b1101;
    localparam logic [3:0] COL_2     = 4'b1011;
    localparam logic [3:0] COL_3     = 4'b0111;
    localparam logic [3:0] ROWS_IDLE = 4'b1111;

    function automatic logic [3:0] col_drive(input logic [1:0] idx);
        logic [3:0] c;
        case (idx)
            2'd0:    c = COL_0;
            2'd1:    c = COL_1;
            2'd2:    c = COL_2;
            default: c = COL_3;
        endcase
        return c;
    endfunction

    // Lowest-index active-low row wins when several rows are pulled low.
    function automatic logic [1:0] low_row_idx(input logic [3:0] pat);
        logic [1:0] r;
        casez (pat)
            4'b???0: r = 2'd0;
            4'b??01: r = 2'd1;
            4'b?011: r = 2'd2;
            default: r = 2'd3;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// keypad_sync: 4-bit two-flop synchronizer for the keypad rows.
// Both stages preset to the idle (all-high) row pattern on reset.
module keypad_sync
    import keypad_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_async,
    output logic [3:0] o_sync
);

    logic [3:0] r_meta;
    logic [3:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= ROWS_IDLE;
            r_sync <= ROWS_IDLE;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 active-low matrix keypad scanner with debounce.
// Optional auto-repeat in PRESSED is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int unsigned N        = 18,
    parameter int unsigned DEBOUNCE = 3,
    parameter int unsigned REPEAT   = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_row,
    output logic [3:0] o_col,
    output logic [3:0] o_key_code,
    output logic       o_key_valid,
    output logic       o_key_held
);

    localparam logic [3:0] DB_LIM = 4'(DEBOUNCE);

    logic [3:0]   w_rs;
    logic         w_idle;
    logic         w_tick;
    logic [3:0]   w_cnt_inc;
    logic [1:0]   w_col_idx_next;

    logic [N-1:0] r_count;
    state_t       r_state;
    logic [1:0]   r_col_idx;
    logic [3:0]   r_col;
    logic [3:0]   r_pat;
    logic [3:0]   r_cnt;
    logic [3:0]   r_key_code;
    logic         r_key_valid;
    logic         r_key_held;

`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned RW = (REPEAT < 2) ? 1 : $clog2(REPEAT);
    logic [RW-1:0] r_rep;
`endif

    keypad_sync u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (i_row),
        .o_sync  (w_rs)
    );

    assign w_idle         = (w_rs == ROWS_IDLE);
    assign w_tick         = &r_count;
    assign w_cnt_inc      = (r_cnt == 4'hF) ? r_cnt : r_cnt + 4'd1;
    assign w_col_idx_next = r_col_idx + 2'd1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    // Accept paths are inlined in SCAN and DEBOUNCE so DEBOUNCE=1 skips the DEBOUNCE state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_SCAN;
            r_col_idx   <= 2'd0;
            r_col       <= COL_0;
            r_pat       <= ROWS_IDLE;
            r_cnt       <= '0;
            r_key_code  <= '0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            r_rep       <= '0;
`endif
        end else begin
            r_key_valid <= 1'b0;
            if (w_tick) begin
                unique case (r_state)
                    S_SCAN: begin
                        if (w_idle) begin
                            r_col_idx <= w_col_idx_next;
                            r_col     <= col_drive(w_col_idx_next);
                        end else begin
                            r_pat <= w_rs;
                            r_cnt <= 4'd1;
                            if (DB_LIM <= 4'd1) begin
                                r_state     <= S_PRESSED;
                                r_key_code  <= {low_row_idx(w_rs), r_col_idx};
                                r_key_valid <= 1'b1;
                                r_key_held  <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
                                r_rep       <= '0;
`endif
                            end else begin
                                r_state <= S_DEBOUNCE;
                            end
                        end
                    end
                    S_DEBOUNCE: begin
                        if (w_rs == r_pat) begin
                            r_cnt <= w_cnt_inc;
                            if (w_cnt_inc >= DB_LIM) begin
                                r_state     <= S_PRESSED;
                                r_key_code  <= {low_row_idx(w_rs), r_col_idx};
                                r_key_valid <= 1'b1;
                                r_key_held  <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
                                r_rep       <= '0;
`endif
                            end
                        end else begin
                            r_state <= S_SCAN;
                        end
                    end
                    S_PRESSED: begin
                        if (w_idle) begin
                            r_cnt <= 4'd1;
`ifdef KEYPAD_REPEAT_EN
                            r_rep <= '0;
`endif
                            if (DB_LIM <= 4'd1) begin
                                r_state    <= S_SCAN;
                                r_key_held <= 1'b0;
                                r_col_idx  <= w_col_idx_next;
                                r_col      <= col_drive(w_col_idx_next);
                            end else begin
                                r_state <= S_RELEASE;
                            end
                        end else begin
`ifdef KEYPAD_REPEAT_EN
                            if (r_rep == RW'(REPEAT - 1)) begin
                                r_key_valid <= 1'b1;
                                r_rep       <= '0;
                            end else begin
                                r_rep <= r_rep + 1'b1;
                            end
`endif
                        end
                    end
                    S_RELEASE: begin
                        if (w_idle) begin
                            r_cnt <= w_cnt_inc;
                            if (w_cnt_inc >= DB_LIM) begin
                                r_state    <= S_SCAN;
                                r_cnt      <= '0;
                                r_key_held <= 1'b0;
                                r_col_idx  <= w_col_idx_next;
                                r_col      <= col_drive(w_col_idx_next);
                            end
                        end else begin
                            r_state <= S_PRESSED;
`ifdef KEYPAD_REPEAT_EN
                            r_rep   <= '0;
`endif
                        end
                    end
                    default: r_state <= S_SCAN;
                endcase
            end
        end
    end

    assign o_col       = r_col;
    assign o_key_code  = r_key_code;
    assign o_key_valid = r_key_valid;
    assign o_key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: self-checking bench for keypad_scan with N=4, DEBOUNCE=3, REPEAT=4.
// A behavioural keypad drives rows from the column; key_valid pulses are scoreboarded.
module tb_keypad_scan;

    typedef struct packed {
        logic [3:0]  code;
        logic [31:0] cyc;
    } pulse_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [31:0] cyc;
    pulse_t      exp_q[$];
    pulse_t      obs_q[$];

    int          mode;
    logic        key_on;
    logic [1:0]  key_row;
    logic [1:0]  key_col;
    wire  [31:0] w_bph = cyc + 32'd8;

    keypad_scan #(.N(4), .DEBOUNCE(3), .REPEAT(4)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_row       (row),
        .o_col       (col),
        .o_key_code  (key_code),
        .o_key_valid (key_valid),
        .o_key_held  (key_held)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 32'd0;
        else        cyc <= cyc + 32'd1;
    end

    // Keypad model: mode 0 single key, 1 bouncing row0 on col0, 2 rows 1 and 3 on col0.
    always_comb begin
        row = 4'b1111;
        case (mode)
            0: if (key_on && col == ~(4'b0001 << key_col)) row[key_row] = 1'b0;
            1: if (col == 4'b1110 && w_bph[4]) row = 4'b1110;
            2: if (col == 4'b1110) row = 4'b0101;
            default: row = 4'b1111;
        endcase
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && key_valid === 1'b1) obs_q.push_back({key_code, cyc});
    end

    task automatic wait_cyc(input logic [31:0] k);
        int unsigned guard = 0;
        while (cyc < k && guard < 20000) begin
            @(posedge clk);
            #1;
            guard++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mode = 0; key_on = 1'b0; key_row = 2'd0; key_col = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (col !== 4'b1110) begin bad++; $display("FAIL rst_col: got %b want 1110", col); end
        total++; if (key_code !== 4'h0) begin bad++; $display("FAIL rst_code: got %h want 0", key_code); end
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", key_valid); end
        total++; if (key_held !== 1'b0) begin bad++; $display("FAIL rst_held: got %b want 0", key_held); end
        @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(5);
        total++; if (obs_q.size() != 0) begin bad++; $display("FAIL rst_release_pulse: got %0d pulses want 0", obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_idle();
        logic [31:0] at_c[6]   = '{32'd15, 32'd16, 32'd31, 32'd32, 32'd48, 32'd64};
        logic [3:0]  at_col[6] = '{4'b1110, 4'b1101, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
        do_reset();
        mode = 0; key_on = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wait_cyc(at_c[i]);
            total++;
            if (col !== at_col[i]) begin bad++; $display("FAIL idle_col@%0d: got %b want %b", at_c[i], col, at_col[i]); end
        end
        wait_cyc(100);
        total++; if (obs_q.size() != 0) begin bad++; $display("FAIL idle_pulse: got %0d pulses want 0", obs_q.size()); end
    endtask

    task automatic test_press();
        pulse_t e, o;
        do_reset();
        mode = 0; key_row = 2'd2; key_col = 2'd1; key_on = 1'b1;
        exp_q.push_back({4'h9, 32'd64});
`ifdef KEYPAD_REPEAT_EN
        for (int i = 1; i <= 5; i++) exp_q.push_back({4'h9, 32'(64 + 64 * i)});
`endif
        wait_cyc(63);
        total++; if (key_held !== 1'b0) begin bad++; $display("FAIL press_held_early: got %b want 0", key_held); end
        wait_cyc(64);
        total++; if (key_valid !== 1'b1) begin bad++; $display("FAIL press_valid: got %b want 1", key_valid); end
        total++; if (key_held !== 1'b1) begin bad++; $display("FAIL press_held: got %b want 1", key_held); end
        total++; if (key_code !== 4'h9) begin bad++; $display("FAIL press_code: got %h want 9", key_code); end
        wait_cyc(65);
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL press_valid_width: got %b want 0", key_valid); end
        wait_cyc(389);
        total++; if (col !== 4'b1101) begin bad++; $display("FAIL press_col_frozen: got %b want 1101", col); end
        total++; if (key_held !== 1'b1) begin bad++; $display("FAIL press_held_long: got %b want 1", key_held); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL press_pulse: got none want code=%h cyc=%0d", e.code, e.cyc); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin bad++; $display("FAIL press_pulse: got code=%h cyc=%0d want code=%h cyc=%0d", o.code, o.cyc, e.code, e.cyc); end
            end
        end
        total++; if (obs_q.size() != 0) begin bad++; $display("FAIL press_extra: got %0d extra pulses want 0", obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_release();
        wait_cyc(390);
        key_on = 1'b0;
        wait_cyc(431);
        total++; if (key_held !== 1'b1) begin bad++; $display("FAIL rel_held_early: got %b want 1", key_held); end
        total++; if (col !== 4'b1101) begin bad++; $display("FAIL rel_col_early: got %b want 1101", col); end
        wait_cyc(432);
        total++; if (key_held !== 1'b0) begin bad++; $display("FAIL rel_held: got %b want 0", key_held); end
        total++; if (col !== 4'b1011) begin bad++; $display("FAIL rel_col: got %b want 1011", col); end
        total++; if (key_code !== 4'h9) begin bad++; $display("FAIL rel_code: got %h want 9", key_code); end
        total++; if (obs_q.size() != 0) begin bad++; $display("FAIL rel_pulse: got %0d pulses want 0", obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_release_glitch();
        pulse_t e, o;
        wait_cyc(433);
        key_row = 2'd3; key_col = 2'd2; key_on = 1'b1;
        exp_q.push_back({4'hE, 32'd480});
        wait_cyc(488); key_on = 1'b0;
        wait_cyc(518); key_on = 1'b1;
        wait_cyc(535);
        total++; if (key_held !== 1'b1) begin bad++; $display("FAIL glitch_held: got %b want 1", key_held); end
        total++; if (col !== 4'b1011) begin bad++; $display("FAIL glitch_col: got %b want 1011", col); end
        wait_cyc(538); key_on = 1'b0;
        wait_cyc(576);
        total++; if (key_held !== 1'b0) begin bad++; $display("FAIL glitch_rel_held: got %b want 0", key_held); end
        total++; if (col !== 4'b0111) begin bad++; $display("FAIL glitch_rel_col: got %b want 0111", col); end
        total++; if (key_code !== 4'hE) begin bad++; $display("FAIL glitch_code: got %h want e", key_code); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL glitch_pulse: got none want code=%h cyc=%0d", e.code, e.cyc); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin bad++; $display("FAIL glitch_pulse: got code=%h cyc=%0d want code=%h cyc=%0d", o.code, o.cyc, e.code, e.cyc); end
            end
        end
        total++; if (obs_q.size() != 0) begin bad++; $display("FAIL glitch_extra: got %0d extra pulses want 0", obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_bounce();
        do_reset();
        mode = 1;
        wait_cyc(17);
        total++; if (col !== 4'b1110) begin bad++; $display("FAIL bounce_col17: got %b want 1110", col); end
        wait_cyc(150);
        total++; if (col !== 4'b1110) begin bad++; $display("FAIL bounce_col150: got %b want 1110", col); end
        total++; if (key_held !== 1'b0) begin bad++; $display("FAIL bounce_held: got %b want 0", key_held); end
        total++; if (obs_q.size() != 0) begin bad++; $display("FAIL bounce_pulse: got %0d pulses want 0", obs_q.size()); end
        mode = 0;
    endtask

    task automatic test_multi_row();
        pulse_t e, o;
        do_reset();
        mode = 2;
        exp_q.push_back({4'h4, 32'd48});
        wait_cyc(60);
        total++; if (key_held !== 1'b1) begin bad++; $display("FAIL multi_held: got %b want 1", key_held); end
        total++; if (key_code !== 4'h4) begin bad++; $display("FAIL multi_code: got %h want 4", key_code); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL multi_pulse: got none want code=%h cyc=%0d", e.code, e.cyc); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin bad++; $display("FAIL multi_pulse: got code=%h cyc=%0d want code=%h cyc=%0d", o.code, o.cyc, e.code, e.cyc); end
            end
        end
        total++; if (obs_q.size() != 0) begin bad++; $display("FAIL multi_extra: got %0d extra pulses want 0", obs_q.size()); end
        mode = 0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        mode = 0; key_row = 2'd2; key_col = 2'd1; key_on = 1'b1;
        wait_cyc(70);
        total++; if (key_held !== 1'b1) begin bad++; $display("FAIL mid_held_before: got %b want 1", key_held); end
        obs_q.delete();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if (col !== 4'b1110) begin bad++; $display("FAIL mid_col: got %b want 1110", col); end
        total++; if (key_code !== 4'h0) begin bad++; $display("FAIL mid_code: got %h want 0", key_code); end
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b want 0", key_valid); end
        total++; if (key_held !== 1'b0) begin bad++; $display("FAIL mid_held: got %b want 0", key_held); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(30);
        total++; if (obs_q.size() != 0) begin bad++; $display("FAIL mid_pulse: got %0d pulses want 0", obs_q.size()); end
        total++; if (key_held !== 1'b0) begin bad++; $display("FAIL mid_held_after: got %b want 0", key_held); end
        key_on = 1'b0;
    endtask

    initial begin
        test_reset();
        test_idle();
        test_press();
        test_release();
        test_release_glitch();
        test_bounce();
        test_multi_row();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
